flopr_pipe: RTL and testbench
=============================

FLOPR_PIPE -- requirements
Module: flopr_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 4, number of register stages (>=1).
REQ-003 SHALL have parameter RESET_VAL, default 0, WIDTH-bit value loaded into every data stage on reset.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset  input  1  reset is synchronous and active-low (asserted when 0).
REQ-006 SHALL have port flush  input  1  synchronous pipeline clear.
REQ-007 SHALL have port in_valid  input  1  upstream word present.
REQ-008 SHALL have port in_ready  output  1  block can accept this cycle.
REQ-009 SHALL have port in_data  input  WIDTH  upstream word.
REQ-010 SHALL have port out_valid  output  1  stage DEPTH-1 holds a word.
REQ-011 SHALL have port out_ready  input  1  downstream accepts this cycle.
REQ-012 SHALL have port out_data  output  WIDTH  stage DEPTH-1 data.
REQ-013 SHALL have port occ  output  $clog2(DEPTH+1)  count of valid stages (present only with FLOPR_PIPE_OCC_EN).

Function
REQ-014 Each stage i SHALL hold valid_i and data_i; stage 0 is the input end, stage DEPTH-1 drives out_valid/out_data.
REQ-015 Stage i SHALL advance when ready_i = !valid_i | ready_(i+1), with ready_DEPTH = out_ready; in_ready = ready_0 & !flush (combinational chain, bubbles collapse).
REQ-016 Transfer in SHALL occur on an edge where in_valid & in_ready; transfer out where out_valid & out_ready.
REQ-017 A word accepted on edge E into an empty unstalled pipe SHALL appear on out_data/out_valid after edge E+DEPTH-1 (DEPTH=1: right after E); throughput one word per cycle.
REQ-018 Words SHALL leave in acceptance order; none duplicated or lost except by flush/reset.
REQ-019 data_i SHALL load only when stage i advances and its source is valid; otherwise it holds its value, so out_data is stable while out_valid & !out_ready.
REQ-020 flush=1 SHALL clear all valid_i at the edge; in_valid in that cycle is discarded; an out transfer in that cycle still counts as delivered; data registers are not modified by flush.
REQ-021 out_data when out_valid=0 SHALL be the last held value (no X).

Reset
REQ-022 On an edge with reset=0: all valid_i=0, all data_i=RESET_VAL, occ=0; out_valid=0, out_data=RESET_VAL, in_ready=1 in the following cycle (when flush=0).
REQ-023 Reset SHALL take priority over flush and any transfer in the same cycle.

Configuration
REQ-024 Macro FLOPR_PIPE_OCC_EN defined: occ port and counter exist; +1 on in-only transfer, -1 on out-only transfer, unchanged on both/neither, 0 after flush or reset; occ SHALL always equal the popcount of valid_i.
REQ-025 Macro undefined: no occ port, no counter logic; all other behaviour identical.

Structure
REQ-026 Package flopr_pipe_pkg SHALL hold the default WIDTH/DEPTH constants and an occupancy-width function for $clog2(DEPTH+1).
REQ-027 One sub-module flopenr_v SHALL implement a single stage (enable-loaded data register plus valid bit, synchronous active-low reset to RESET_VAL/0), instantiated DEPTH times by generate.

Verification (WIDTH=32, DEPTH=4)
REQ-028 Full pipe, reset=0 for one edge -> out_valid=0, out_data=32'h0, occ=0, in_ready=1.
REQ-029 Stream 32'hABCD1234, 32'h0200500C, 32'h00000001 on consecutive edges, out_ready=1 -> each appears 3 edges after acceptance, in order, one per cycle.
REQ-030 out_ready=0, offer 5 words -> first 4 accepted, in_ready=0 on 5th, occ=4, out_data=32'hABCD1234 held; out_ready=1 -> drain in order, occ falls 4,3,2,1,0.
REQ-031 out_ready=0, send A, two idle cycles, send B -> A in stage 3, B in stage 2 (collapsed), occ=2, in_ready=1.
REQ-032 Full pipe, flush=1 with in_valid=1, in_data=32'hDEADBEEF -> next cycle out_valid=0, occ=0, 32'hDEADBEEF never emerges.
REQ-033 Mid-stream reset=0 together with flush=1 -> reset values per REQ-022; streaming then resumes with correct latency.

Source files
------------

// File: rtl/flopr_pipe_pkg.sv
// Shared constants and helpers for the flopr_pipe register pipeline.
// The occupancy counter in flopr_pipe is only built when FLOPR_PIPE_OCC_EN is defined.
package flopr_pipe_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 4;

    // Bits needed to count 0..depth valid stages inclusive
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/flopenr_v.sv
// One pipeline stage: an enable-loaded data register plus its valid bit.
// Reset is synchronous and active-low; flush clears the valid bit but leaves
// the data register alone so the output never shows X or a discarded word.
module flopenr_v
    import flopr_pipe_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             en,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // Valid bit follows the upstream stage when this stage advances; flush empties it
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (en) begin
            valid <= src_valid;
        end
    end

    // Data only captures real words, so bubbles and flushes leave the last value held
    always_ff @(posedge clk) begin
        if (!reset) begin
            data <= RESET_VAL;
        end else if (en && src_valid && !flush) begin
            data <= src_data;
        end
    end

endmodule

// File: rtl/flopr_pipe.sv
// flopr_pipe: DEPTH-stage valid/ready register pipeline with collapsing bubbles.
// Each stage may advance whenever it is empty or the stage after it advances,
// so the ready chain is combinational from out_ready back to in_ready.
// Define FLOPR_PIPE_OCC_EN to add the occ port and its occupancy counter.
module flopr_pipe
    import flopr_pipe_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter int               DEPTH     = DEFAULT_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data
`ifdef FLOPR_PIPE_OCC_EN
    ,
    output logic [occ_width(DEPTH)-1:0] occ
`endif
);

    logic [DEPTH-1:0] valid;
    logic [WIDTH-1:0] data [DEPTH];
    logic [DEPTH:0]   ready;

    assign ready[DEPTH] = out_ready;
    assign in_ready     = ready[0] & ~flush;
    assign out_valid    = valid[DEPTH-1];
    assign out_data     = data[DEPTH-1];

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             src_valid;
        logic [WIDTH-1:0] src_data;

        assign ready[i] = ~valid[i] | ready[i+1];

        if (i == 0) begin : g_head
            assign src_valid = in_valid;
            assign src_data  = in_data;
        end else begin : g_body
            assign src_valid = valid[i-1];
            assign src_data  = data[i-1];
        end

        flopenr_v #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk       (clk),
            .reset     (reset),
            .flush     (flush),
            .en        (ready[i]),
            .src_valid (src_valid),
            .src_data  (src_data),
            .valid     (valid[i]),
            .data      (data[i])
        );
    end

`ifdef FLOPR_PIPE_OCC_EN
    localparam int              OCCW    = occ_width(DEPTH);
    localparam logic [OCCW-1:0] OCC_ONE = OCCW'(1);

    logic in_xfer;
    logic out_xfer;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    // Occupancy tracks accepted minus delivered words, matching the valid-bit popcount
    always_ff @(posedge clk) begin
        if (!reset) begin
            occ <= '0;
        end else if (flush) begin
            occ <= '0;
        end else if (in_xfer && !out_xfer) begin
            occ <= occ + OCC_ONE;
        end else if (!in_xfer && out_xfer) begin
            occ <= occ - OCC_ONE;
        end
    end
`endif

endmodule

// File: tb/tb_flopr_pipe.sv
// Directed testbench for flopr_pipe (WIDTH=32, DEPTH=4).
// Occupancy checks are active only when FLOPR_PIPE_OCC_EN is defined.
module tb_flopr_pipe;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
`ifdef FLOPR_PIPE_OCC_EN
    logic [2:0]  occ;
`endif

    int vectors;
    int miscompares;

    flopr_pipe #(
        .WIDTH     (32),
        .DEPTH     (4),
        .RESET_VAL (32'h0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef FLOPR_PIPE_OCC_EN
        ,
        .occ       (occ)
`endif
    );

    // Free-running 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkOcc(input string tag, input logic [31:0] expected);
`ifdef FLOPR_PIPE_OCC_EN
        checkOutput(tag, {29'b0, occ}, expected);
`else
        if (expected > 32'd4) $display("[TB] occ expectation out of range for %s", tag);
`endif
    endtask

    task automatic applyStimulus(input logic rst, input logic fl, input logic iv,
                                 input logic [31:0] id, input logic ordy);
        reset     = rst;
        flush     = fl;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] words [5];
        vectors     = 0;
        miscompares = 0;
        words[0] = 32'hABCD1234;
        words[1] = 32'h11111111;
        words[2] = 32'h22222222;
        words[3] = 32'h33333333;
        words[4] = 32'h44444444;

        // Power-on reset
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        reset = 1'b1;
        #1;
        checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_out_data", out_data, 32'h0);
        checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);
        checkOcc("rst_occ", 32'd0);

        // Three-word stream, each word appears 3 edges after acceptance
        applyStimulus(1'b1, 1'b0, 1'b1, 32'hABCD1234, 1'b1);
        checkOutput("str_e1_valid", {31'b0, out_valid}, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0200500C, 1'b1);
        checkOutput("str_e2_valid", {31'b0, out_valid}, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h00000001, 1'b1);
        checkOutput("str_e3_valid", {31'b0, out_valid}, 32'd0);
        checkOcc("str_e3_occ", 32'd3);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("str_e4_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("str_e4_data", out_data, 32'hABCD1234);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("str_e5_data", out_data, 32'h0200500C);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("str_e6_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("str_e6_data", out_data, 32'h00000001);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("str_e7_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("str_e7_hold", out_data, 32'h00000001);
        checkOcc("str_e7_occ", 32'd0);

        // Stalled output: four words fill the pipe, the fifth is refused
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, words[i], 1'b0);
        end
        in_data = words[4];
        #1;
        checkOutput("stall_in_ready", {31'b0, in_ready}, 32'd0);
        checkOutput("stall_out_data", out_data, 32'hABCD1234);
        checkOcc("stall_occ", 32'd4);
        applyStimulus(1'b1, 1'b0, 1'b1, words[4], 1'b0);
        checkOutput("stall_hold_data", out_data, 32'hABCD1234);
        checkOutput("stall_hold_valid", {31'b0, out_valid}, 32'd1);
        checkOcc("stall_hold_occ", 32'd4);
        for (int i = 1; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
            checkOutput($sformatf("drain%0d_data", i), out_data, words[i]);
            checkOcc($sformatf("drain%0d_occ", i), 32'(4 - i));
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("drain_end_valid", {31'b0, out_valid}, 32'd0);
        checkOcc("drain_end_occ", 32'd0);

        // Bubble collapse: A, two idle cycles, B, then let B slide up behind A
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h55555555, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h66666666, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("col_out_data", out_data, 32'h55555555);
        checkOutput("col_in_ready", {31'b0, in_ready}, 32'd1);
        checkOcc("col_occ", 32'd2);
        out_ready = 1'b1;
        #1;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("col_b_next", out_data, 32'h66666666);
        checkOutput("col_b_valid", {31'b0, out_valid}, 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("col_empty", {31'b0, out_valid}, 32'd0);

        // Flush on a full pipe while offering DEADBEEF
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, words[i], 1'b0);
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0);
        checkOutput("fl_in_ready_during", {31'b0, in_ready}, 32'd0);
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        checkOutput("fl_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("fl_in_ready", {31'b0, in_ready}, 32'd1);
        checkOcc("fl_occ", 32'd0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
            checkOutput($sformatf("fl_quiet%0d_valid", i), {31'b0, out_valid}, 32'd0);
            checkOutput($sformatf("fl_quiet%0d_data", i), out_data, 32'hABCD1234);
        end

        // Flush on an empty pipe still blocks the input for that cycle
        flush    = 1'b1;
        in_valid = 1'b1;
        #1;
        checkOutput("fl_empty_in_ready", {31'b0, in_ready}, 32'd0);

        // Full pipe, then reset together with flush and traffic
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, words[i], 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h77777777, 1'b1);
        reset    = 1'b1;
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        checkOutput("mrst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("mrst_out_data", out_data, 32'h0);
        checkOutput("mrst_in_ready", {31'b0, in_ready}, 32'd1);
        checkOcc("mrst_occ", 32'd0);

        // Streaming resumes with the normal latency
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h12345678, 1'b1);
        checkOutput("res_e1_valid", {31'b0, out_valid}, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("res_e3_valid", {31'b0, out_valid}, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("res_e4_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("res_e4_data", out_data, 32'h12345678);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
